// File: rtl/hht_mem_pkg.sv
// Shared types and helpers for the HHT memory-side responder.
// Holds the miss marker, the region selector and the address range check.
package hht_mem_pkg;

   localparam int unsigned RANGE_W = 64;
   localparam logic [31:0] MISS_DATA = 32'd99999;

   typedef enum logic [0:0] {
      REG_COL = 1'b0,
      REG_VEC = 1'b1
   } region_e;

   typedef struct packed {
      logic               hit;
      logic [RANGE_W-1:0] offset;
   } range_t;

   // Hit when addr lies in [base, base + depth); offset is only meaningful on a hit.
   function automatic range_t in_range(input logic [RANGE_W-1:0] addr,
                                       input logic [RANGE_W-1:0] base,
                                       input logic [RANGE_W-1:0] depth);
      range_t r;
      r.offset = addr - base;
      r.hit    = (addr >= base) && (r.offset < depth);
      return r;
   endfunction

endpackage

// File: rtl/hht_region_ram.sv
// One memory region: synchronous read-first RAM with range-checked read and
// write ports, a two-stage read pipeline and miss indications.
module hht_region_ram
   import hht_mem_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] base,
   input  logic          rd,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] rdata,
   output logic          vld,
   output logic          rd_miss_c,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_miss_c
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0]    mem [DEPTH];
   range_t           rd_rng;
   range_t           wr_rng;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             p_vld;
   logic             p_miss;
   logic [DW-1:0]    p_data;

   // Range checks for both ports against the region base.
   always_comb begin
      rd_rng    = in_range(RANGE_W'(addr), RANGE_W'(base), RANGE_W'(DEPTH));
      wr_rng    = in_range(RANGE_W'(wr_addr), RANGE_W'(base), RANGE_W'(DEPTH));
      rd_idx    = rd_rng.hit ? IDX_W'(rd_rng.offset) : '0;
      wr_idx    = IDX_W'(wr_rng.offset);
      wr_miss_c = wr_en && !wr_rng.hit;
      rd_miss_c = p_vld && p_miss;
   end

   // Array read at the accepting edge sees the pre-write contents (read-first).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_vld  <= 1'b0;
         p_miss <= 1'b0;
         p_data <= '0;
      end else begin
         p_vld <= rd;
         if (rd) begin
            p_miss <= !rd_rng.hit;
            p_data <= mem[rd_idx];
         end
      end
   end

   // Output register; data holds while no response is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld   <= 1'b0;
         rdata <= '0;
      end else begin
         vld <= p_vld;
         if (p_vld) begin
            rdata <= p_miss ? DW'(MISS_DATA) : p_data;
         end
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_rng.hit) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/hht_mem_responder.sv
// Memory-side responder for the HHT control engine: column data on port 1,
// vector values on port 2, shared preload write port, sticky miss flag.
module hht_mem_responder
   import hht_mem_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned COL_DEPTH = 512,
   parameter int unsigned VEC_DEPTH = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [AW-1:0]    col_base,
   input  logic [AW-1:0]    vec_base,
   input  logic             rd1,
   input  logic [AW-1:0]    addr1,
   output logic [DW-1:0]    dataIn1,
   output logic             vld1,
   input  logic             rd2,
   input  logic [AW-1:0]    addr2,
   output logic [DW-1:0]    dataIn2,
   output logic             vld2,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DW-1:0]    wr_data,
   output logic             miss_err,
   output logic [CNT_W-1:0] rd_cnt1,
   output logic [CNT_W-1:0] rd_cnt2
);

   region_e wr_region;
   logic    col_wr_en_c;
   logic    vec_wr_en_c;
   logic    col_rd_miss_c;
   logic    vec_rd_miss_c;
   logic    col_wr_miss_c;
   logic    vec_wr_miss_c;

   // Only the selected region sees the write strobe.
   always_comb begin
      wr_region   = region_e'(wr_sel);
      col_wr_en_c = wr_en && (wr_region == REG_COL);
      vec_wr_en_c = wr_en && (wr_region == REG_VEC);
   end

   hht_region_ram #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (COL_DEPTH)
   ) u_col_ram (
      .clk       (Clk),
      .rst_n     (Rst),
      .base      (col_base),
      .rd        (rd1),
      .addr      (addr1),
      .rdata     (dataIn1),
      .vld       (vld1),
      .rd_miss_c (col_rd_miss_c),
      .wr_en     (col_wr_en_c),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_miss_c (col_wr_miss_c)
   );

   hht_region_ram #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (VEC_DEPTH)
   ) u_vec_ram (
      .clk       (Clk),
      .rst_n     (Rst),
      .base      (vec_base),
      .rd        (rd2),
      .addr      (addr2),
      .rdata     (dataIn2),
      .vld       (vld2),
      .rd_miss_c (vec_rd_miss_c),
      .wr_en     (vec_wr_en_c),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_miss_c (vec_wr_miss_c)
   );

   // Read misses are flagged on the edge that launches the response, so the
   // flag rises together with the offending valid pulse.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         miss_err <= 1'b0;
      end else if (col_rd_miss_c || vec_rd_miss_c || col_wr_miss_c || vec_wr_miss_c) begin
         miss_err <= 1'b1;
      end
   end

   // Saturating counts of accepted requests, hit or miss.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rd_cnt1 <= '0;
         rd_cnt2 <= '0;
      end else begin
         if (rd1 && (rd_cnt1 != '1)) begin
            rd_cnt1 <= rd_cnt1 + CNT_W'(1);
         end
         if (rd2 && (rd_cnt2 != '1)) begin
            rd_cnt2 <= rd_cnt2 + CNT_W'(1);
         end
      end
   end

endmodule
